// File: rtl/mic_frontend_multi.sv
// N-channel microphone front-end: per-channel DC-offset calibration,
// saturating offset subtraction and integer decimation on a shared strobe.
// Handshake: sample_valid_in is a single-cycle strobe qualifying all channels
// of sample_in together (no back-pressure); sample_valid_out is a single-cycle
// strobe one cycle after a qualifying input, and sample_out holds between strobes.
// The calibration FSM state is directly visible on cal_busy_out (1 = ACCUM).
module mic_frontend_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int CAL_LOG2 = 10,
  parameter int DECIM    = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      sample_valid_in,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      cal_trigger_in,
  output logic                      cal_busy_out,
  output logic                      cal_done_out,
  output logic [CHANNELS*WIDTH-1:0] offset_out,
  output logic                      sample_valid_out,
  output logic [CHANNELS*WIDTH-1:0] sample_out
);

  localparam int AW = WIDTH + CAL_LOG2;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [CAL_LOG2-1:0]             cnt_q, cnt_d;
  logic [CHANNELS-1:0][AW-1:0]     acc_q, acc_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  offset_q, offset_d;
  logic                            done_q, done_d;
  logic [PW-1:0]                   phase_q, phase_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  out_q, out_d;
  logic                            vld_q, vld_d;

  logic [CHANNELS-1:0][WIDTH-1:0]  smp;
  logic [CHANNELS-1:0][AW-1:0]     sum;
  logic [CHANNELS-1:0][WIDTH:0]    wide;
  logic [CHANNELS-1:0][WIDTH-1:0]  diff;

  assign smp = sample_in;

  // Per-channel running sum and saturating offset-corrected sample.
  always_comb begin
    sum  = '0;
    wide = '0;
    diff = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum[k]  = acc_q[k] + {{CAL_LOG2{smp[k][WIDTH-1]}}, smp[k]};
      wide[k] = {smp[k][WIDTH-1], smp[k]} - {offset_q[k][WIDTH-1], offset_q[k]};
      if (!done_q) begin
        diff[k] = smp[k];
      end else if (wide[k][WIDTH] != wide[k][WIDTH-1]) begin
        // Overflowed the signed range: clamp toward the sign of the true result.
        diff[k] = wide[k][WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        diff[k] = wide[k][WIDTH-1:0];
      end
    end
  end

  // Calibration FSM next state; offsets load on the edge absorbing the last sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    offset_d = offset_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (cal_trigger_in) begin
          state_d = ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (sample_valid_in) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            // Arithmetic shift right by CAL_LOG2 (floor) is simply the upper slice.
            for (int k = 0; k < CHANNELS; k++) begin
              offset_d[k] = sum[k][AW-1:CAL_LOG2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decimation phase and registered output strobe/data.
  always_comb begin
    phase_d = phase_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    if (sample_valid_in) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
      if (phase_q == '0) begin
        out_d = diff;
        vld_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      offset_q <= '0;
      done_q   <= 1'b0;
      phase_q  <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      offset_q <= offset_d;
      done_q   <= done_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
    end
  end

  assign cal_busy_out     = (state_q == ACCUM);
  assign cal_done_out     = done_q;
  assign offset_out       = offset_q;
  assign sample_valid_out = vld_q;
  assign sample_out       = out_q;

endmodule
